// File: rtl/red_target_stream_gen.sv
// VGA-timed synthetic pixel source: one red box on a blue field, bouncing once per frame.
// Optional build macro RED_NOISE_EN adds LFSR speckle that flips isolated pixels' class.
module red_target_stream_gen #(
   parameter int          H_ACTIVE = 640,
   parameter int          H_TOTAL  = 800,
   parameter int          V_ACTIVE = 480,
   parameter int          V_TOTAL  = 525,
   parameter int          BOX_W    = 32,
   parameter int          BOX_H    = 24,
   parameter int          STEP     = 4,
   parameter int          INIT_X   = 0,
   parameter int          INIT_Y   = 0,
   parameter logic [35:0] RED_RGB  = 36'hFFF000000,
   parameter logic [35:0] BG_RGB   = 36'h000000FFF
) (
   input  logic        iVgaClk,
   input  logic        reset,
   input  logic        iRun,
   input  logic        iLoad,
   input  logic [9:0]  iLoadX,
   input  logic [8:0]  iLoadY,
   output logic [35:0] oPixel12bRgb,
   output logic [9:0]  oHIndex,
   output logic [8:0]  oVIndex,
   output logic        oVgaHRequest,
   output logic        oVgaVRequest,
   output logic [9:0]  oBoxX,
   output logic [8:0]  oBoxY,
   output logic        oFrameStart
);

   localparam logic [9:0]         H_ACT   = 10'(H_ACTIVE);
   localparam logic [9:0]         H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0]         V_ACT   = 10'(V_ACTIVE);
   localparam logic [9:0]         V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0]         X_MAX   = 10'(H_ACTIVE - BOX_W);
   localparam logic [8:0]         Y_MAX   = 9'(V_ACTIVE - BOX_H);
   localparam logic signed [11:0] X_MAX_S = 12'(H_ACTIVE - BOX_W);
   localparam logic signed [10:0] Y_MAX_S = 11'(V_ACTIVE - BOX_H);
   localparam logic signed [11:0] STEP_X  = 12'(STEP);
   localparam logic signed [10:0] STEP_Y  = 11'(STEP);
   localparam logic [10:0]        BOX_W_E = 11'(BOX_W);
   localparam logic [9:0]         BOX_H_E = 10'(BOX_H);

   logic [9:0]         hcnt, vcnt;
   logic [9:0]         box_x, box_x_nxt;
   logic [8:0]         box_y, box_y_nxt;
   logic               dir_x, dir_y, dir_x_nxt, dir_y_nxt;  // 1 = moving toward 0
   logic               load_pend;
   logic               h_act, v_act, boundary, in_box, red;
   logic signed [11:0] nx;
   logic signed [10:0] ny;

`ifdef RED_NOISE_EN
   logic [15:0] lfsr;

   // x^16+x^14+x^13+x^11+1, advanced only on active pixels
   always_ff @(posedge iVgaClk) begin
      if (reset)
         lfsr <= 16'hACE1;
      else if (h_act)
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end
`endif

   always_comb begin
      v_act    = (vcnt < V_ACT);
      h_act    = (hcnt < H_ACT) && v_act;
      boundary = (hcnt == 10'd0) && (vcnt == V_ACT);
      in_box   = (hcnt >= box_x) && ({1'b0, hcnt} < ({1'b0, box_x} + BOX_W_E)) &&
                 (vcnt >= {1'b0, box_y}) && (vcnt < ({1'b0, box_y} + BOX_H_E));
`ifdef RED_NOISE_EN
      red      = in_box ^ (lfsr[7:0] == 8'd0);
`else
      red      = in_box;
`endif
   end

   // Box motion, evaluated only on the first blank line so each frame sees one position
   always_comb begin
      box_x_nxt = box_x;
      box_y_nxt = box_y;
      dir_x_nxt = dir_x;
      dir_y_nxt = dir_y;
      nx        = $signed({2'b00, box_x}) + (dir_x ? -STEP_X : STEP_X);
      ny        = $signed({2'b00, box_y}) + (dir_y ? -STEP_Y : STEP_Y);
      if (boundary) begin
         if (load_pend || iLoad) begin
            box_x_nxt = (iLoadX > X_MAX) ? X_MAX : iLoadX;
            box_y_nxt = (iLoadY > Y_MAX) ? Y_MAX : iLoadY;
         end else if (iRun) begin
            if (nx > X_MAX_S) begin
               box_x_nxt = X_MAX;
               dir_x_nxt = 1'b1;
            end else if (nx[11]) begin
               box_x_nxt = 10'd0;
               dir_x_nxt = 1'b0;
            end else begin
               box_x_nxt = nx[9:0];
            end
            if (ny > Y_MAX_S) begin
               box_y_nxt = Y_MAX;
               dir_y_nxt = 1'b1;
            end else if (ny[10]) begin
               box_y_nxt = 9'd0;
               dir_y_nxt = 1'b0;
            end else begin
               box_y_nxt = ny[8:0];
            end
         end
      end
   end

   always_ff @(posedge iVgaClk) begin
      if (reset) begin
         hcnt         <= '0;
         vcnt         <= '0;
         box_x        <= 10'(INIT_X);
         box_y        <= 9'(INIT_Y);
         dir_x        <= 1'b0;
         dir_y        <= 1'b0;
         load_pend    <= 1'b0;
         oPixel12bRgb <= '0;
         oHIndex      <= '0;
         oVIndex      <= '0;
         oVgaHRequest <= 1'b0;
         oVgaVRequest <= 1'b0;
         oFrameStart  <= 1'b0;
      end else begin
         if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
         end else begin
            hcnt <= hcnt + 10'd1;
         end
         box_x        <= box_x_nxt;
         box_y        <= box_y_nxt;
         dir_x        <= dir_x_nxt;
         dir_y        <= dir_y_nxt;
         load_pend    <= boundary ? 1'b0 : (load_pend | iLoad);
         oPixel12bRgb <= h_act ? (red ? RED_RGB : BG_RGB) : 36'd0;
         oHIndex      <= h_act ? hcnt : 10'd0;
         oVIndex      <= h_act ? vcnt[8:0] : 9'd0;
         oVgaHRequest <= h_act;
         oVgaVRequest <= v_act;
         oFrameStart  <= (hcnt == 10'd0) && (vcnt == 10'd0);
      end
   end

   assign oBoxX = box_x;
   assign oBoxY = box_y;

endmodule

// File: tb/tb_red_target_stream_gen.sv
// Scoreboard bench for red_target_stream_gen on a shrunken raster (40x30 active, 50x34 total).
module tb_red_target_stream_gen;

   localparam int          HA = 40, HT = 50, VA = 30, VT = 34, BW = 8, BH = 6, ST = 4;
   localparam logic [35:0] RED = 36'hFFF000000;
   localparam logic [35:0] BG  = 36'h000000FFF;

   logic        clk = 1'b0;
   logic        reset, iRun, iLoad;
   logic [9:0]  iLoadX;
   logic [8:0]  iLoadY;
   logic [35:0] oPixel12bRgb;
   logic [9:0]  oHIndex, oBoxX;
   logic [8:0]  oVIndex, oBoxY;
   logic        oVgaHRequest, oVgaVRequest, oFrameStart;

   red_target_stream_gen #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
      .BOX_W(BW), .BOX_H(BH), .STEP(ST), .INIT_X(0), .INIT_Y(0),
      .RED_RGB(RED), .BG_RGB(BG)
   ) dut (
      .iVgaClk(clk), .reset(reset), .iRun(iRun), .iLoad(iLoad),
      .iLoadX(iLoadX), .iLoadY(iLoadY),
      .oPixel12bRgb(oPixel12bRgb), .oHIndex(oHIndex), .oVIndex(oVIndex),
      .oVgaHRequest(oVgaHRequest), .oVgaVRequest(oVgaVRequest),
      .oBoxX(oBoxX), .oBoxY(oBoxY), .oFrameStart(oFrameStart)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   errs    = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int x, input int y);
      exp_t e;
      e.x = x;
      e.y = y;
      q.push_back(e);
   endtask

   task automatic wait_fs();
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!oFrameStart && n < 4000);
      chk("frame_start_seen", int'(oFrameStart), 1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_stream", int'(|{oPixel12bRgb, oHIndex, oVIndex, oVgaHRequest,
                               oVgaVRequest, oFrameStart}), 0);
      chk("rst_box", int'({oBoxY, oBoxX}), 0);
   endtask

   // Controls applied during frame i; box expected in frame i+1 (hand-derived)
   int t_run[10] = '{0, 1, 1, 0, 1, 1, 1, 1, 1, 1};
   int t_ld [10] = '{0, 0, 0, 0, 1, 0, 0, 2, 0, 0};  // 1 = mid-frame pulse, 2 = on boundary cycle
   int t_lx [10] = '{0, 0, 0, 0, 34, 0, 0, 2, 0, 0};
   int t_ly [10] = '{0, 0, 0, 0, 26, 0, 0, 2, 0, 0};
   int t_ex [10] = '{0, 4, 8, 8, 32, 32, 28, 2, 0, 4};
   int t_ey [10] = '{0, 4, 8, 8, 24, 24, 20, 2, 0, 4};

   initial begin
      reset  = 1'b1;
      iRun   = 1'b0;
      iLoad  = 1'b0;
      iLoadX = '0;
      iLoadY = '0;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk_reset_outputs();
      end
      push(0, 0);
      reset = 1'b0;

      for (int s = 0; s < 10; s++) begin
         wait_fs();
         iRun   = t_run[s][0];
         iLoadX = 10'(t_lx[s]);
         iLoadY = 9'(t_ly[s]);
         push(t_ex[s], t_ey[s]);
         if (t_ld[s] == 1) begin
            repeat (10) @(posedge clk);
            #1 iLoad = 1'b1;
            @(posedge clk);
            #1 iLoad = 1'b0;
         end else if (t_ld[s] == 2) begin
            repeat (HT * VA - 1) @(posedge clk);
            #1 iLoad = 1'b1;
            @(posedge clk);
            #1 iLoad = 1'b0;
         end
      end

      // Pending load then mid-frame reset at (30,20): reset must drop the load
      wait_fs();
      iRun   = 1'b0;
      iLoadX = 10'd20;
      iLoadY = 9'd20;
      @(posedge clk);
      #1 iLoad = 1'b1;
      @(posedge clk);
      #1 iLoad = 1'b0;
      repeat (1027) @(posedge clk);
      push(0, 0);
      #1 reset = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk_reset_outputs();
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_frame_start", int'(oFrameStart), 1);
      chk("post_rst_hreq", int'(oVgaHRequest), 1);
      chk("post_rst_box", int'({oBoxY, oBoxX}), 0);
      push(0, 0);
      wait_fs();
      repeat (5) @(posedge clk);
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   // Monitor: pops one expected box per frame start and checks the whole raster
   initial begin
      exp_t e;
      int   cyc = 0, fs_cyc = 0, ls_cyc = 0;
      int   col = 0, line = 0, lines = 0, hreq_cnt = 0, red_cnt = 0;
      int   pix_err = 0, lp_err = 0;
      bit   fs_valid = 0, in_frame = 0, prev_h = 0, prev_v = 0, want_red;
      e.x = -1;
      e.y = -1;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            in_frame = 0;
            fs_valid = 0;
            prev_h   = 0;
            prev_v   = 0;
            continue;
         end
         if (oFrameStart) begin
            if (q.size() == 0) begin
               chk("exp_available", 0, 1);
               e.x = -1;
               e.y = -1;
            end else begin
               e = q.pop_front();
               chk("box_x", int'(oBoxX), e.x);
               chk("box_y", int'(oBoxY), e.y);
            end
            if (fs_valid) chk("frame_period", cyc - fs_cyc, HT * VT);
            fs_valid = 1;
            fs_cyc   = cyc;
            in_frame = 1;
            lines    = 0;
            hreq_cnt = 0;
            red_cnt  = 0;
            pix_err  = 0;
            lp_err   = 0;
            prev_h   = 0;
         end
         if (in_frame) begin
            if (oVgaHRequest) begin
               if (!prev_h) begin
                  line = lines;
                  lines++;
                  col = 0;
                  if (lines > 1 && (cyc - ls_cyc) != HT) lp_err++;
                  ls_cyc = cyc;
               end
               want_red = (col >= e.x) && (col < e.x + BW) && (line >= e.y) && (line < e.y + BH);
               if (oPixel12bRgb != (want_red ? RED : BG)) pix_err++;
               if (int'(oHIndex) != col || int'(oVIndex) != line) pix_err++;
               if (int'(oBoxX) != e.x || int'(oBoxY) != e.y || !oVgaVRequest) pix_err++;
               if (oFrameStart && (col != 0 || line != 0)) pix_err++;
               if (oPixel12bRgb == RED) red_cnt++;
               hreq_cnt++;
               col++;
            end else begin
               if (oPixel12bRgb != 36'd0 || oHIndex != 10'd0 || oVIndex != 9'd0 || oFrameStart)
                  pix_err++;
            end
            if (prev_v && !oVgaVRequest) begin
               chk("hreq_clocks", hreq_cnt, HA * VA);
               chk("active_lines", lines, VA);
               chk("line_period_errs", lp_err, 0);
               chk("pixel_errs", pix_err, 0);
               chk("red_pixels", red_cnt, BW * BH);
               in_frame = 0;
            end
         end
         prev_h = oVgaHRequest;
         prev_v = oVgaVRequest;
      end
   end

endmodule
